iiitb_vending_machine: RTL and testbench



---
 rtl/iiitb_vending_machine.sv | 58 +++++
 tb/tb_iiitb_vending_machine.sv | 123 ++++++++++++
 2 files changed

// File: rtl/iiitb_vending_machine.sv
// iiitb_vending_machine: 15-unit single-item vending FSM taking 5/10 coins, registered pulse outputs.
// Define IIITB_VM_INVALID_REFUND_EN to make an invalid coin (11) abort and refund held credit.
module iiitb_vending_machine (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] in,
   output logic       out,
   output logic [1:0] change
);
   typedef enum logic [1:0] {S0, S5, S10} state_t;
   state_t     state_q, state_d;
   logic       out_q, out_d;
   logic [1:0] change_q, change_d;
   logic [1:0] refund;
   // Held credit expressed directly as a change code: S5 -> 01, S10 -> 10.
   assign refund = (state_q == S5) ? 2'b01 : (state_q == S10) ? 2'b10 : 2'b00;
   always_comb begin
      state_d  = state_q;
      out_d    = 1'b0;
      change_d = 2'b00;
      case (in)
         2'b00: begin
            state_d  = S0;
            change_d = refund;
         end
         2'b01: begin
            state_d = (state_q == S0) ? S5 : (state_q == S5) ? S10 : S0;
            out_d   = (state_q == S10);
         end
         2'b10: begin
            state_d  = (state_q == S0) ? S10 : S0;
            out_d    = (state_q != S0);
            change_d = (state_q == S10) ? 2'b01 : 2'b00;
         end
         default: begin
`ifdef IIITB_VM_INVALID_REFUND_EN
            state_d  = S0;
            change_d = refund;
`else
            state_d  = state_q;
`endif
         end
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S0;
         out_q    <= 1'b0;
         change_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         out_q    <= out_d;
         change_q <= change_d;
      end
   end
   assign out    = out_q;
   assign change = change_q;
endmodule

// File: tb/tb_iiitb_vending_machine.sv
// tb_iiitb_vending_machine: scoreboard bench; a credit-arithmetic model queues expected pulses, a monitor checks them.
module tb_iiitb_vending_machine;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] in_r  = 2'b00;
   logic       out_w;
   logic [1:0] change_w;
   logic [2:0] exp_q[$];
   int         credit = 0;
   int         checks = 0;
   int         passed = 0;

   iiitb_vending_machine dut (
      .clock (clock),
      .reset (reset),
      .in    (in_r),
      .out   (out_w),
      .change(change_w)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got out=%b change=%b, expected out=%b change=%b",
                    name, got[2], got[1:0], exp[2], exp[1:0]);
   endtask

   // Model works in coin units: sum credit, vend at >= 15, change is the excess.
   task automatic drive(input logic [1:0] c);
      int         total;
      logic       o;
      logic [1:0] ch;
      @(negedge clock);
      in_r = c;
      o    = 1'b0;
      ch   = 2'b00;
      if (c == 2'b00) begin
         ch     = 2'(credit / 5);
         credit = 0;
      end else if (c == 2'b11) begin
`ifdef IIITB_VM_INVALID_REFUND_EN
         ch     = 2'(credit / 5);
         credit = 0;
`endif
      end else begin
         total = credit + ((c == 2'b01) ? 5 : 10);
         if (total >= 15) begin
            o      = 1'b1;
            ch     = 2'((total - 15) / 5);
            credit = 0;
         end else credit = total;
      end
      exp_q.push_back({o, ch});
   endtask

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) check("cycle", {out_w, change_w}, exp_q.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no finish, expected finish before 1ms");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         in_r = 2'($urandom_range(0, 3));
         @(posedge clock);
         #1;
         check("reset_hold", {out_w, change_w}, 3'b000);
      end
      @(negedge clock);
      in_r  = 2'b00;
      reset = 1'b1;
      foreach (exp_q[i]) ; // queue is empty here
      drive(2'b01); drive(2'b10); drive(2'b11); drive(2'b00);
      drive(2'b10); drive(2'b01); drive(2'b00);
      drive(2'b10); drive(2'b10);
      drive(2'b01); drive(2'b00); drive(2'b10); drive(2'b00);
      drive(2'b01); drive(2'b01); drive(2'b01);
      drive(2'b10); drive(2'b11); drive(2'b01);
      drive(2'b00);
      drive(2'b01); drive(2'b10);
      @(posedge clock);
      #2;
      reset = 1'b0;
      in_r  = 2'b00;
      credit = 0;
      #1;
      check("async_clear", {out_w, change_w}, 3'b000);
      @(negedge clock);
      reset = 1'b1;
      drive(2'b10);
      @(posedge clock);
      #2;
      reset = 1'b0;
      in_r  = 2'b00;
      credit = 0;
      #1;
      check("async_s10", {out_w, change_w}, 3'b000);
      @(negedge clock);
      reset = 1'b1;
      drive(2'b01);
      drive(2'b00);
      for (int i = 0; i < 300; i++) drive(2'($urandom_range(0, 3)));
      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clock);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
